// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Snoops a time-multiplexed, active-low 7-segment display bus. It recovers
//   the BCD value shown on each digit and keeps it in a per-digit register
//   file with valid status.
//
//   Each scan slot is debounced: the sampled {an_n, seg_n} must stay
//   unchanged for STABLE_CYCLES samples. Exactly one capture is then taken
//   per dwell, and only when a single anode is active.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   an_n         [DIGITS-1:0] anode enables, active-low (bit i low = digit i)
//   seg_n        [6:0] segment lines, active-low, {a,b,c,d,e,f,g}
//   bcd_out      [4*DIGITS-1:0] recovered digits, digit i at [4i+3:4i]
//   digit_valid  [DIGITS-1:0] digit i's last capture decoded to 0-9
//   update       one-cycle pulse on every capture
//   upd_idx      [2:0] digit index of the capture, 0 when update is low
//   bad_pattern  one-cycle pulse when a capture sees a non-decimal,
//                non-blank pattern
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [6:0]            seg_n,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  update,
  output logic [2:0]            upd_idx,
  output logic                  bad_pattern
);

  localparam int            CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  // Returns {is_digit, is_blank, nibble}. This is the inverse of the
  // driver's encoding. Blank and unknown patterns both yield nibble F.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: seg_decode = {2'b10, 4'd0};
      7'b1001111: seg_decode = {2'b10, 4'd1};
      7'b0010010: seg_decode = {2'b10, 4'd2};
      7'b0000110: seg_decode = {2'b10, 4'd3};
      7'b1001100: seg_decode = {2'b10, 4'd4};
      7'b0100100: seg_decode = {2'b10, 4'd5};
      7'b0100000: seg_decode = {2'b10, 4'd6};
      7'b0001111: seg_decode = {2'b10, 4'd7};
      7'b0000000: seg_decode = {2'b10, 4'd8};
      7'b0000100: seg_decode = {2'b10, 4'd9};
      7'b1111111: seg_decode = {2'b01, 4'hF};
      default:    seg_decode = {2'b00, 4'hF};
    endcase
  endfunction

  logic [DIGITS-1:0]   s_an_q,   s_an_d;
  logic [6:0]          s_seg_q,  s_seg_d;
  logic [CW-1:0]       cnt_q,    cnt_d;
  logic                captured_q, captured_d;
  logic [4*DIGITS-1:0] bcd_q,    bcd_d;
  logic [DIGITS-1:0]   valid_q,  valid_d;
  logic                update_q, update_d;
  logic [2:0]          upd_idx_q, upd_idx_d;
  logic                bad_q,    bad_d;

  logic       in_same;
  logic       seen_low;
  logic       multi_low;
  logic       one_low;
  logic [2:0] sel_idx;
  logic       capture;
  logic [5:0] dec;

  // Locate the single active anode in the sampled enables. All-high
  // (blanking gap) and multiple-low both suppress capture.
  always_comb begin
    seen_low  = 1'b0;
    multi_low = 1'b0;
    sel_idx   = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s_an_q[i]) begin
        if (seen_low) multi_low = 1'b1;
        seen_low = 1'b1;
        sel_idx  = 3'(i);
      end
    end
    one_low = seen_low & ~multi_low;
  end

  always_comb begin
    in_same = ({an_n, seg_n} == {s_an_q, s_seg_q});
    dec     = seg_decode(s_seg_q);
    capture = in_same && (cnt_q == CNT_MAX) && !captured_q && one_low;

    s_an_d  = an_n;
    s_seg_d = seg_n;

    // The counter saturates, so a long dwell cannot wrap around and
    // re-trigger. The captured flag blocks repeats within one dwell.
    if (!in_same)                cnt_d = '0;
    else if (cnt_q == CNT_MAX)   cnt_d = cnt_q;
    else                         cnt_d = cnt_q + 1'b1;

    if (!in_same)     captured_d = 1'b0;
    else if (capture) captured_d = 1'b1;
    else              captured_d = captured_q;

    update_d  = capture;
    upd_idx_d = capture ? sel_idx : 3'd0;
    bad_d     = capture & ~dec[5] & ~dec[4];

    bcd_d   = bcd_q;
    valid_d = valid_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (capture && (sel_idx == 3'(i))) begin
        bcd_d[4*i +: 4] = dec[3:0];
        valid_d[i]      = dec[5];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_an_q     <= '1;
      s_seg_q    <= '1;
      cnt_q      <= '0;
      captured_q <= 1'b0;
      bcd_q      <= '1;
      valid_q    <= '0;
      update_q   <= 1'b0;
      upd_idx_q  <= 3'd0;
      bad_q      <= 1'b0;
    end else begin
      s_an_q     <= s_an_d;
      s_seg_q    <= s_seg_d;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
      update_q   <= update_d;
      upd_idx_q  <= upd_idx_d;
      bad_q      <= bad_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign upd_idx     = upd_idx_q;
  assign bad_pattern = bad_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder (DIGITS=4, STABLE_CYCLES=4).
// Stimulus pushes each expected capture (cycle, digit index, bad flag)
// into a queue. A monitor pops an entry on every update pulse.
module tb_seg_scan_decoder;

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                         P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                         P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000,
                         P9 = 7'b0000100, PB = 7'b1111111, PX = 7'b1110000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an_n = 4'b1111;
  logic [6:0]  seg_n = PB;
  logic [15:0] bcd_out;
  logic [3:0]  digit_valid;
  logic        update;
  logic [2:0]  upd_idx;
  logic        bad_pattern;

  typedef struct {
    int         cyc;
    logic [2:0] idx;
    logic       bad;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  logic [6:0] xpat [3] = '{P4, P6, P8};
  logic [3:0] xval [3] = '{4'd4, 4'd6, 4'd8};

  seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid),
    .update      (update),
    .upd_idx     (upd_idx),
    .bad_pattern (bad_pattern)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change 1 time unit after an edge. The first sample is taken at
  // the next edge, so the capture lands STABLE_CYCLES edges later, which is
  // cyc + 5.
  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n,
                       input bit cap, input logic [2:0] idx, input bit bad);
    exp_t e;
    an_n  = an;
    seg_n = seg;
    if (cap) begin
      e.cyc = cyc + 5;
      e.idx = idx;
      e.bad = bad;
      sb.push_back(e);
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap();
    dwell(4'b1111, PB, 2, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (update) begin
        if (sb.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_update: got idx %0d bad %0b, expected no update (cyc %0d)",
                   upd_idx, bad_pattern, cyc);
        end else begin
          e = sb.pop_front();
          chk("update_cycle", cyc, e.cyc);
          chk("upd_idx", 32'(upd_idx), 32'(e.idx));
          chk("bad_pattern", 32'(bad_pattern), 32'(e.bad));
        end
      end else begin
        chk("idle_upd_idx", 32'(upd_idx), 32'd0);
        chk("idle_bad_pattern", 32'(bad_pattern), 32'd0);
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset held while the inputs toggle.
    for (int i = 0; i < 8; i++) begin
      an_n  = (i % 2 == 0) ? 4'b1110 : 4'b1101;
      seg_n = (i % 2 == 0) ? P2 : P5;
      @(negedge clk);
      chk("rst_bcd", 32'(bcd_out), 32'hFFFF);
      chk("rst_valid", 32'(digit_valid), 32'h0);
      chk("rst_update", 32'(update), 32'h0);
    end
    an_n  = 4'b1111;
    seg_n = PB;
    @(posedge clk);
    #1 rst_n = 1'b1;
    gap();

    // Normal capture on digit 0.
    dwell(4'b1110, P2, 10, 1'b1, 3'd0, 1'b0);
    chk("normal_bcd", 32'(bcd_out), 32'hFFF2);
    chk("normal_valid", 32'(digit_valid), 32'b0001);
    gap();

    // Full scan: digits 3,2,1,0 show 9,0,7,5.
    dwell(4'b0111, P9, 6, 1'b1, 3'd3, 1'b0); gap();
    dwell(4'b1011, P0, 6, 1'b1, 3'd2, 1'b0); gap();
    dwell(4'b1101, P7, 6, 1'b1, 3'd1, 1'b0); gap();
    dwell(4'b1110, P5, 6, 1'b1, 3'd0, 1'b0); gap();
    chk("scan_bcd", 32'(bcd_out), 32'h9075);
    chk("scan_valid", 32'(digit_valid), 32'b1111);

    // Remaining decimal patterns on digit 3, then restore 9.
    for (int i = 0; i < 3; i++) begin
      dwell(4'b0111, xpat[i], 6, 1'b1, 3'd3, 1'b0); gap();
      chk("decode_digit3", 32'(bcd_out[15:12]), 32'(xval[i]));
    end
    dwell(4'b0111, P9, 6, 1'b1, 3'd3, 1'b0); gap();

    // Glitch: a short 0 followed by a stable 1 on digit 1.
    dwell(4'b1101, P0, 3, 1'b0, 3'd0, 1'b0);
    dwell(4'b1101, P1, 6, 1'b1, 3'd1, 1'b0); gap();
    chk("glitch_bcd", 32'(bcd_out), 32'h9015);

    // Invalid pattern, then blank, on digit 2.
    dwell(4'b1011, PX, 6, 1'b1, 3'd2, 1'b1); gap();
    chk("invalid_bcd", 32'(bcd_out), 32'h9F15);
    chk("invalid_valid", 32'(digit_valid), 32'b1011);
    dwell(4'b1011, PB, 6, 1'b1, 3'd2, 1'b0); gap();
    chk("blank_bcd", 32'(bcd_out), 32'h9F15);
    chk("blank_valid", 32'(digit_valid), 32'b1011);

    // Two anodes low: no capture, digits retained.
    dwell(4'b1100, P8, 8, 1'b0, 3'd0, 1'b0); gap();
    chk("multi_bcd", 32'(bcd_out), 32'h9F15);
    chk("multi_valid", 32'(digit_valid), 32'b1011);

    // Reset asserted two cycles into a valid dwell.
    an_n  = 4'b1110;
    seg_n = P3;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_bcd", 32'(bcd_out), 32'hFFFF);
    chk("midrst_valid", 32'(digit_valid), 32'h0);
    chk("midrst_update", 32'(update), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dwell(4'b1110, P3, 8, 1'b1, 3'd0, 1'b0);
    chk("postrst_bcd", 32'(bcd_out), 32'hFFF3);
    chk("postrst_valid", 32'(digit_valid), 32'b0001);
    gap();

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
